// File: rtl/spi_miso_deserializer.sv
// SPI mode-0 MISO receive front end: synchronises sclk/miso/frame_en, assembles bytes, strobes each one and flags framing errors.
// Optional build macro SPI_RX_LSB_FIRST_EN: first received bit lands in bit 0 (default is MSB first).
module spi_miso_deserializer #(
    parameter int DSIZE       = 8,
    parameter int FRAME_BYTES = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_sclk,
    input  logic             spi_miso,
    input  logic             frame_en,
    output logic [DSIZE-1:0] wdata,
    output logic             wdata_valid,
    output logic [3:0]       byte_cnt,
    output logic             frame_done,
    output logic             frame_err,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    localparam int             BW        = (DSIZE > 1) ? $clog2(DSIZE) : 1;
    localparam logic [BW-1:0]  LAST_BIT  = BW'(DSIZE - 1);
    localparam logic [3:0]     LAST_BYTE = 4'(FRAME_BYTES);

    logic             sclk_s1_q, sclk_s2_q, sclk_prev_q;
    logic             miso_s1_q, miso_s2_q;
    logic             fen_s1_q, fen_s2_q, fen_prev_q;
    state_e           state_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [3:0]       byte_cnt_q;
    logic [DSIZE-1:0] shift_q, shift_d;
    logic [DSIZE-1:0] wdata_q;
    logic             wdata_valid_q, frame_done_q, frame_err_q;
    logic             sclk_rise, fen_rise, fen_fall;
    logic [3:0]       byte_cnt_d;

    // miso shares the sclk synchroniser depth, so the sampled bit is the pin value at the sclk edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            miso_s1_q   <= 1'b0;
            miso_s2_q   <= 1'b0;
            fen_s1_q    <= 1'b0;
            fen_s2_q    <= 1'b0;
            fen_prev_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each flop see the previous stage's old value, forming a real chain.
            sclk_s1_q   <= spi_sclk;
            sclk_s2_q   <= sclk_s1_q;
            sclk_prev_q <= sclk_s2_q;
            miso_s1_q   <= spi_miso;
            miso_s2_q   <= miso_s1_q;
            fen_s1_q    <= frame_en;
            fen_s2_q    <= fen_s1_q;
            fen_prev_q  <= fen_s2_q;
        end
    end

    assign sclk_rise  = sclk_s2_q & ~sclk_prev_q;
    assign fen_rise   = fen_s2_q & ~fen_prev_q;
    assign fen_fall   = ~fen_s2_q & fen_prev_q;
    assign byte_cnt_d = byte_cnt_q + 4'd1;

`ifdef SPI_RX_LSB_FIRST_EN
    assign shift_d = {miso_s2_q, shift_q[DSIZE-1:1]};
`else
    assign shift_d = {shift_q[DSIZE-2:0], miso_s2_q};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            shift_q       <= '0;
            wdata_q       <= '0;
            wdata_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            wdata_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fen_rise) begin
                        bit_cnt_q   <= '0;
                        byte_cnt_q  <= '0;
                        shift_q     <= '0;
                        frame_err_q <= 1'b0;
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A frame_en fall beats a coincident sclk edge; the partial byte is dropped.
                    if (fen_fall) begin
                        if (bit_cnt_q != '0 || byte_cnt_q < LAST_BYTE) frame_err_q <= 1'b1;
                        bit_cnt_q <= '0;
                        shift_q   <= '0;
                        state_q   <= IDLE;
                    end else if (sclk_rise) begin
                        shift_q <= shift_d;
                        if (bit_cnt_q == LAST_BIT) begin
                            wdata_q       <= shift_d;
                            wdata_valid_q <= 1'b1;
                            bit_cnt_q     <= '0;
                            byte_cnt_q    <= byte_cnt_d;
                            if (byte_cnt_d == LAST_BYTE) begin
                                frame_done_q <= 1'b1;
                                state_q      <= DONE;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                        end
                    end
                end
                DONE: begin
                    if (sclk_rise) frame_err_q <= 1'b1;
                    if (fen_fall)  state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wdata       = wdata_q;
    assign wdata_valid = wdata_valid_q;
    assign byte_cnt    = byte_cnt_q;
    assign frame_done  = frame_done_q;
    assign frame_err   = frame_err_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: doc/spi_miso_deserializer.md
# spi_miso_deserializer

Front-end receive stage of the SPI master read path. Samples the serial MISO line against the SPI bit clock, assembles bytes, and presents each completed byte with a one-cycle strobe. The output FIFO stage downstream uses that strobe as its write strobe. A frame is FRAME_BYTES bytes, matching the 15-byte (120-bit) buffer the output FIFO stage assembles. Framing errors are flagged so the downstream stage can discard a bad frame.

## Interface
Parameters:
- DSIZE, 8: bits per byte; width of wdata.
- FRAME_BYTES, 15: bytes per frame; range 1..15.

Ports:
- clk  in  1  system clock; all state on posedge. Must run at least 4× spi_sclk.
- rst  in  1  asynchronous, active-low reset.
- spi_sclk  in  1  SPI bit clock, asynchronous to clk, mode 0 (idle low, sample on rising edge).
- spi_miso  in  1  serial data from the slave.
- frame_en  in  1  high for the duration of a frame (asserted by the SPI master control).
- wdata  out  DSIZE  last completed byte; held until the next byte completes.
- wdata_valid  out  1  one-clk pulse when wdata updates; drives the FIFO write strobe.
- byte_cnt  out  4  bytes completed in the current frame, 0..FRAME_BYTES.
- frame_done  out  1  one-clk pulse when byte FRAME_BYTES completes.
- frame_err  out  1  sticky error flag; cleared at the next frame start.
- busy  out  1  high in SHIFT and DONE.

## Operation
- Input synchronisation:
  - spi_sclk, spi_miso and frame_en each pass through 2-flop synchronisers.
  - A third flop on sclk gives the registered previous value.
  - sclk_rise = sync_sclk & ~prev_sclk.
- State machine states: IDLE, SHIFT, DONE.
- IDLE:
  - On a rising edge of synced frame_en: clear bit_cnt, byte_cnt, shift register and frame_err; go to SHIFT.
  - sclk_rise is ignored.
- SHIFT, on sclk_rise:
  - shift_reg <= {shift_reg[DSIZE-2:0], miso_sync} (MSB first).
  - bit_cnt increments.
- SHIFT, on sclk_rise when bit_cnt == DSIZE-1:
  - wdata <= the assembled byte (including the current bit).
  - wdata_valid <= 1.
  - bit_cnt <= 0; byte_cnt <= byte_cnt+1.
  - If byte_cnt+1 == FRAME_BYTES: frame_done <= 1 and go to DONE.
- SHIFT, frame_en falls:
  - If bit_cnt != 0 or byte_cnt < FRAME_BYTES: frame_err <= 1.
  - Any partial byte is discarded.
  - Go to IDLE.
- DONE:
  - Any sclk_rise sets frame_err (overrun); no data is shifted and no wdata_valid is issued.
  - frame_en falling returns to IDLE.
- Simultaneous sclk_rise and frame_en fall in SHIFT: the fall wins and the bit is discarded.
- A frame_en rising edge while not in IDLE is ignored.

## Timing
- Reset values: wdata=0, wdata_valid=0, byte_cnt=0, frame_done=0, frame_err=0, busy=0; state IDLE; all synchronisers 0.
- Latency from clk edge k (the first edge that samples the 8th spi_sclk rising edge at the pin):
  - sclk_rise is seen in the cycle following edge k+1.
  - wdata and wdata_valid are registered at edge k+2, so wdata_valid is high from edge k+2 to edge k+3.
- spi_miso uses the same synchroniser depth, so each sampled bit is the pin value at the spi_sclk rising edge (slave holds data one clk period past the edge).
- frame_done is coincident with the wdata_valid of the last byte.
- wdata_valid and frame_done are exactly one clk wide; at most one wdata_valid per sclk_rise.
- Reset asserted mid-frame clears everything immediately (asynchronous); no strobe is emitted on reset release.

## Configuration
- SPI_RX_LSB_FIRST_EN:
  - Defined: shift_reg <= {miso_sync, shift_reg[DSIZE-1:1]}, so the first received bit lands in bit 0.
  - Undefined (default): MSB-first as above.
  - All counting, framing and timing are identical in both builds.

## Test plan
- Reset: hold rst low with sclk toggling → all outputs 0, busy=0; release → outputs stay 0 until frame_en rises.
- Full frame: frame_en high, send bytes 0x01..0x0F MSB first → 15 wdata_valid pulses with wdata 0x01..0x0F in order, byte_cnt ends at 15, one frame_done with byte 0x0F, frame_err=0.
- Abort: drop frame_en after 12 bits → exactly one wdata_valid (byte 1), frame_err=1, state IDLE; next frame_en rise clears frame_err.
- Overrun: complete 15 bytes, then 3 extra sclk edges before frame_en falls → frame_err=1, no 16th wdata_valid, byte_cnt stays 15.
- Bit order: serial bits 0,0,0,0,0,0,0,1 → wdata=0x01 by default; wdata=0x80 with SPI_RX_LSB_FIRST_EN defined.
- Mid-frame reset: assert rst after 5 bytes → outputs 0 immediately; a fresh frame after release delivers 15 correct bytes.
